// File: rtl/cache_refill_ctrl.sv
// Miss/refill and write-through sequencer for the MEM-stage 2-way data cache.
// Optional hit/miss statistics counters are built when STATS_EN is defined.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  LdSrcM,
    input  logic                  StSrcM,
    input  logic [ADDR_WIDTH-1:0] addrM,
    input  logic [DATA_WIDTH-1:0] wdataM,
    input  logic                  hit,
    output logic                  stall,
    output logic                  cacheFill,
    output logic [DATA_WIDTH-1:0] cacheFillData,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memReady
`ifdef STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  hitCount,
    output logic [CNT_WIDTH-1:0]  missCount
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        FILL    = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   st_go, ld_miss, ld_hit;

    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("CNT_WIDTH must be at least 1");
    end

    // A store wins over a simultaneous load; the load is simply not seen.
    assign st_go   = (state == IDLE) & StSrcM;
    assign ld_miss = (state == IDLE) & ~StSrcM & LdSrcM & ~hit;
    assign ld_hit  = (state == IDLE) & ~StSrcM & LdSrcM &  hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        cacheFill = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        case (state)
            IDLE: begin
                if (StSrcM) begin
                    state_nxt = WR_WAIT;
                    stall     = 1'b1;
                end else if (LdSrcM && !hit) begin
                    state_nxt = RD_WAIT;
                    stall     = 1'b1;
                end
            end
            RD_WAIT: begin
                memReq = 1'b1;
                stall  = 1'b1;
                if (memReady) state_nxt = FILL;
            end
            FILL: begin
                cacheFill = 1'b1;
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            WR_WAIT: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                // The pipeline may advance in the very cycle the write completes.
                stall  = ~memReady;
                if (memReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Keep stall quiet while reset is held even if the MEM stage shows a miss.
        if (!rst_n) stall = 1'b0;
    end

    // Request address/data are captured on accept and held until IDLE returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memAddr  <= '0;
            memWdata <= '0;
        end else if (st_go) begin
            memAddr  <= addrM;
            memWdata <= wdataM;
        end else if (ld_miss) begin
            memAddr  <= addrM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cacheFillData <= '0;
        else if (state == RD_WAIT && memReady)  cacheFillData <= memRdata;
    end

`ifdef STATS_EN
    logic justFilled;

    // The load that triggered a refill re-looks-up right after FILL; that hit is not new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) justFilled <= 1'b0;
        else        justFilled <= (state == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (ld_hit && !justFilled && hitCount != '1)
                hitCount <= hitCount + 1'b1;
            if (ld_miss && missCount != '1)
                missCount <= missCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl (counter checks only with STATS_EN).
module tb_cache_refill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          LdSrcM, StSrcM, hit, memReady;
    logic [AW-1:0] addrM;
    logic [DW-1:0] wdataM, memRdata;
    logic          stall, cacheFill, memReq, memWe;
    logic [DW-1:0] cacheFillData, memWdata;
    logic [AW-1:0] memAddr;
`ifdef STATS_EN
    logic [CW-1:0] hitCount, missCount;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall, n_fill, n_rd;
    logic stable;

    cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .LdSrcM(LdSrcM), .StSrcM(StSrcM),
        .addrM(addrM), .wdataM(wdataM), .hit(hit), .stall(stall),
        .cacheFill(cacheFill), .cacheFillData(cacheFillData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady)
`ifdef STATS_EN
        , .hitCount(hitCount), .missCount(missCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Sample on the falling edge and tally per-test event counts.
    task automatic tick();
        @(negedge clk);
        if (stall)            n_stall++;
        if (cacheFill)        n_fill++;
        if (memReq && !memWe) n_rd++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_stall = 0;
        n_fill  = 0;
        n_rd    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; LdSrcM = 0; StSrcM = 0; hit = 0; memReady = 0;
        addrM = '0; wdataM = '0; memRdata = '0;
        #3;
        chk("rst_stall",  32'(stall), 32'd0);
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memWe",  32'(memWe), 32'd0);
        chk("rst_fill",   32'(cacheFill), 32'd0);
        chk("rst_addr",   memAddr, 32'd0);
        chk("rst_wdata",  memWdata, 32'd0);
        chk("rst_fdata",  cacheFillData, 32'd0);
`ifdef STATS_EN
        chk("rst_hitc",   32'(hitCount), 32'd0);
        chk("rst_missc",  32'(missCount), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // Load hit at 0x100
        clr();
        LdSrcM = 1; hit = 1; addrM = 32'h100;
        tick(); chk("hit_stall", 32'(stall), 32'd0);
        nxt();
        LdSrcM = 0; hit = 0;
        tick();
        chk("hit_nstall", 32'(n_stall), 32'd0);
        chk("hit_nreq",   32'(n_rd), 32'd0);
`ifdef STATS_EN
        chk("hit_hitc",  32'(hitCount), 32'd1);
        chk("hit_missc", 32'(missCount), 32'd0);
`endif
        nxt();

        // Load miss at 0x104, memReady in first RD_WAIT cycle
        clr();
        LdSrcM = 1; hit = 0; addrM = 32'h104;
        tick(); chk("miss_detect_stall", 32'(stall), 32'd1);
        nxt();
        memReady = 1; memRdata = 32'hA5;
        tick();
        chk("miss_req",  32'(memReq), 32'd1);
        chk("miss_we",   32'(memWe), 32'd0);
        chk("miss_addr", memAddr, 32'h104);
        nxt();
        memReady = 0; memRdata = 32'h0;
        tick();
        chk("miss_fill",  32'(cacheFill), 32'd1);
        chk("miss_fdata", cacheFillData, 32'hA5);
        nxt();
        hit = 1;
        tick(); chk("miss_relookup_stall", 32'(stall), 32'd0);
        nxt();
        LdSrcM = 0; hit = 0;
        tick();
        chk("miss_nstall", 32'(n_stall), 32'd3);
        chk("miss_nfill",  32'(n_fill), 32'd1);
`ifdef STATS_EN
        chk("miss_missc", 32'(missCount), 32'd1);
        chk("miss_hitc",  32'(hitCount), 32'd1);
`endif
        nxt();

        // Store 0xFF to 0x200, memReady after 4 wait cycles
        clr();
        StSrcM = 1; addrM = 32'h200; wdataM = 32'hFF;
        tick(); chk("st_detect_stall", 32'(stall), 32'd1);
        nxt();
        addrM = 32'h999; wdataM = 32'h11;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            memReady = (i == 4);
            tick();
            if (memReq !== 1'b1 || memWe !== 1'b1 || memAddr !== 32'h200 || memWdata !== 32'hFF)
                stable = 1'b0;
            if (i == 4) chk("st_stall_fall", 32'(stall), 32'd0);
            nxt();
        end
        memReady = 0; StSrcM = 0;
        tick();
        chk("st_stable", 32'(stable), 32'd1);
        chk("st_nstall", 32'(n_stall), 32'd5);
        chk("st_nfill",  32'(n_fill), 32'd0);
        chk("st_idle_req", 32'(memReq), 32'd0);
        nxt();

        // Load and store together with a miss: store wins
        clr();
        LdSrcM = 1; StSrcM = 1; hit = 0; addrM = 32'h300; wdataM = 32'h77;
        tick();
        nxt();
        memReady = 1;
        tick();
        chk("both_we",    32'(memWe), 32'd1);
        chk("both_addr",  memAddr, 32'h300);
        chk("both_wdata", memWdata, 32'h77);
        chk("both_stall", 32'(stall), 32'd0);
        nxt();
        memReady = 0; LdSrcM = 0; StSrcM = 0;
        tick();
        chk("both_nrd", 32'(n_rd), 32'd0);
`ifdef STATS_EN
        chk("both_missc", 32'(missCount), 32'd1);
`endif
        nxt();

        // Reset during the 2nd RD_WAIT cycle, then the same miss refills
        LdSrcM = 1; hit = 0; addrM = 32'h108;
        tick(); nxt();
        tick(); nxt();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(memReq), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_addr",  memAddr, 32'd0);
        tick();
        chk("arst_fill", 32'(cacheFill), 32'd0);
        #1 rst_n = 1'b1;
        clr();
        nxt();
        memReady = 1; memRdata = 32'h5A;
        tick();
        chk("rearm_req",  32'(memReq), 32'd1);
        chk("rearm_addr", memAddr, 32'h108);
        nxt();
        memReady = 0; memRdata = 32'h0;
        tick();
        chk("rearm_fdata", cacheFillData, 32'h5A);
        nxt();
        hit = 1;
        tick(); nxt();
        LdSrcM = 0; hit = 0;
        tick();
        chk("rearm_nfill", 32'(n_fill), 32'd1);
`ifdef STATS_EN
        chk("rearm_missc", 32'(missCount), 32'd1);
        chk("rearm_hitc",  32'(hitCount), 32'd0);
`endif
        nxt();

`ifdef STATS_EN
        // 2^4+3 = 19 consecutive load hits saturate the 4-bit counter
        LdSrcM = 1; hit = 1;
        repeat (14) begin tick(); nxt(); end
        chk("sat_mid", 32'(hitCount), 32'd14);
        repeat (5) begin tick(); nxt(); end
        LdSrcM = 0; hit = 0;
        tick();
        chk("sat_hold", 32'(hitCount), 32'd15);
        chk("sat_missc", 32'(missCount), 32'd1);
        nxt();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss/refill and write-through sequencer for the MEM-stage 2-way data cache. It watches the load/store type strobes and the cache hit flag, stalls the pipeline on a load miss or a store, and fetches from main memory over a req/ready handshake. On a load miss it then pulses a one-cycle fill into the cache; on a store it writes the store through to memory. It sits between the MEM stage, the data cache and the data memory, and is the only master of the memory port.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- CNT_WIDTH, 16, statistics counter width (used only with STATS_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- LdSrcM  in  1  load (lbu) in MEM stage
- StSrcM  in  1  store (sb) in MEM stage
- addrM  in  ADDR_WIDTH  MEM-stage address
- wdataM  in  DATA_WIDTH  MEM-stage store data
- hit  in  1  combinational cache hit for addrM
- stall  out  1  freeze IF..MEM stages
- cacheFill  out  1  one-cycle cache write strobe for refill
- cacheFillData  out  DATA_WIDTH  refill data (valid with cacheFill)
- memReq  out  1  memory request
- memWe  out  1  1 = write, 0 = read (valid with memReq)
- memAddr  out  ADDR_WIDTH  latched request address
- memWdata  out  DATA_WIDTH  latched store data
- memRdata  in  DATA_WIDTH  read data, sampled when memReq & memReady
- memReady  in  1  memory completes the current request this cycle
- hitCount, missCount  out  CNT_WIDTH  statistics (STATS_EN only)

## Operation
- States: IDLE, RD_WAIT, FILL, WR_WAIT. Reset state IDLE.
- IDLE:
  - StSrcM=1: latch addrM/wdataM, go to WR_WAIT. A store takes priority if LdSrcM is also 1; the load is ignored.
  - LdSrcM=1 & hit=0: latch addrM, go to RD_WAIT.
  - LdSrcM=1 & hit=1: no action.
- RD_WAIT: memReq=1, memWe=0. On memReady, capture memRdata into the fill register and go to FILL.
- FILL: cacheFill=1 for exactly one cycle with the captured data, then go to IDLE. The held load re-looks-up and hits.
- WR_WAIT: memReq=1, memWe=1. On memReady, go to IDLE.
- stall = (IDLE & (StSrcM | (LdSrcM & ~hit))) | RD_WAIT | FILL | (WR_WAIT & ~memReady).
- memAddr and memWdata are stable for the whole time memReq is high. memReq never deasserts before memReady.
- memReady is ignored whenever memReq=0.
- The controller does no write-allocate. A store hit is updated by the cache itself; a store miss does not fill.

## Timing
- Reset values, applied immediately on rst_n low:
  - stall, cacheFill, memReq, memWe = 0
  - memAddr, memWdata, cacheFillData = 0
  - counters = 0
- Reset mid-RD_WAIT or mid-WR_WAIT aborts the transaction. memReq drops asynchronously and no fill is issued.
- Load hit: 0 stall cycles.
- Load miss, with memReady in the first RD_WAIT cycle: stall high for 3 cycles (IDLE detect, RD_WAIT, FILL). The load completes on the 4th cycle. Each extra memory wait cycle adds 1.
- Store, with memReady in the first WR_WAIT cycle: stall high for 1 cycle (the IDLE detect cycle). The pipeline advances in the cycle memReady is seen.
- stall has a combinational path from hit, LdSrcM, StSrcM and memReady. Next state and all other outputs are registered or decoded from state.
- Back-to-back: a new request may be accepted in the IDLE cycle right after FILL or WR_WAIT.

## Configuration
- STATS_EN defined:
  - missCount increments on each IDLE->RD_WAIT transition.
  - hitCount increments on each IDLE load hit, except the re-lookup hit in the cycle right after FILL. An internal justFilled flag tracks this.
  - Both counters saturate at all-ones.
- STATS_EN undefined: the counters, the ports and the justFilled flag are absent. Control behaviour is identical.

## Test plan
- Reset, then load hit at 0x100: stall=0, memReq never asserted; with STATS_EN, hitCount=1, missCount=0.
- Load miss at 0x104, memReady in the first RD_WAIT cycle, memRdata=0xA5: stall high 3 cycles; memAddr=0x104, memWe=0; cacheFill pulses once with cacheFillData=0xA5; missCount=1, hitCount unchanged.
- Store 0xFF to 0x200, memReady delayed 4 cycles: memReq=1, memWe=1, memAddr=0x200, memWdata=0xFF, all stable; stall falls in the memReady cycle; no cacheFill.
- LdSrcM=1, StSrcM=1, hit=0 together: WR_WAIT entered, no read issued, missCount unchanged.
- rst_n low in the 2nd RD_WAIT cycle: memReq=0 at once, state IDLE, no cacheFill; after release, the same miss refills normally.
- 2^CNT_WIDTH+3 load hits (reduced to CNT_WIDTH=4 in the bench): hitCount holds at 0xF.
